// File: rtl/conv33_window_if.sv
// Pixel-stream in / 3x3-window out bundle between a raster source, conv33_window and the
// 3x3 convolution calculator.
interface conv33_window_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28
);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    logic                         start;
    logic                         in_valid;
    logic signed [DATA_WIDTH-1:0] in_data;

    logic signed [DATA_WIDTH-1:0] data_0_0, data_0_1, data_0_2;
    logic signed [DATA_WIDTH-1:0] data_1_0, data_1_1, data_1_2;
    logic signed [DATA_WIDTH-1:0] data_2_0, data_2_1, data_2_2;
    logic                         conv33_en;
    logic [RW-1:0]                out_row;
    logic [CW-1:0]                out_col;
    logic                         frame_done;

    modport master (
        output start, in_valid, in_data,
        input  data_0_0, data_0_1, data_0_2, data_1_0, data_1_1, data_1_2,
        input  data_2_0, data_2_1, data_2_2, conv33_en, out_row, out_col, frame_done
    );

    modport slave (
        input  start, in_valid, in_data,
        output data_0_0, data_0_1, data_0_2, data_1_0, data_1_1, data_1_2,
        output data_2_0, data_2_1, data_2_2, conv33_en, out_row, out_col, frame_done
    );
endinterface

// File: rtl/conv33_window.sv
// Raster-to-3x3 sliding-window generator. Two line buffers hold rows r-1 and r-2; only
// fully populated (unpadded) windows are strobed on conv33_en.
module conv33_window #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28
) (
    input logic            clk,
    input logic            rst,
    conv33_window_if.slave bus
);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    typedef logic signed [DATA_WIDTH-1:0] pix_t;

    logic [RW-1:0] row_q, row_d, row_cur;
    logic [CW-1:0] col_q, col_d, col_cur;
    logic          last_row, last_col;
    pix_t          lb0 [IMG_W];
    pix_t          lb1 [IMG_W];
    pix_t          lb0_rd, lb1_rd;
    pix_t          win_q [3][3];
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // start overrides the counters before this cycle's pixel is placed
    assign row_cur  = bus.start ? '0 : row_q;
    assign col_cur  = bus.start ? '0 : col_q;
    assign last_row = (row_cur == RW'(IMG_H - 1));
    assign last_col = (col_cur == CW'(IMG_W - 1));
    assign lb0_rd   = lb0[col_cur];
    assign lb1_rd   = lb1[col_cur];

    always_comb begin
        row_d  = row_cur;
        col_d  = col_cur;
        en_d   = 1'b0;
        done_d = 1'b0;
        if (bus.in_valid) begin
            en_d   = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
            done_d = en_d && last_row && last_col;
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q     <= '0;
            col_q     <= '0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            en_q   <= en_d;
            done_q <= done_d;
            if (bus.in_valid) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb1_rd;
                win_q[1][2] <= lb0_rd;
                win_q[2][2] <= bus.in_data;
                if (en_d) begin
                    out_row_q <= row_cur - RW'(2);
                    out_col_q <= col_cur - CW'(2);
                end
            end
        end
    end

    // Line buffer contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb1[col_cur] <= lb0_rd;
            lb0[col_cur] <= bus.in_data;
        end
    end

    assign bus.data_0_0   = win_q[0][0];
    assign bus.data_0_1   = win_q[0][1];
    assign bus.data_0_2   = win_q[0][2];
    assign bus.data_1_0   = win_q[1][0];
    assign bus.data_1_1   = win_q[1][1];
    assign bus.data_1_2   = win_q[1][2];
    assign bus.data_2_0   = win_q[2][0];
    assign bus.data_2_1   = win_q[2][1];
    assign bus.data_2_2   = win_q[2][2];
    assign bus.conv33_en  = en_q;
    assign bus.frame_done = done_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
endmodule

// File: tb/tb_conv33_window.sv
// Directed bench for conv33_window on a 5x5 frame: vector table built per scenario,
// applied cycle by cycle with window/index/strobe expectations from a pixel formula.
module tb_conv33_window;
    localparam int unsigned W = 5;
    localparam int unsigned H = 5;

    typedef struct packed {
        logic        valid;
        logic        start;
        logic [7:0]  data;
        logic        exp_en;
        logic        exp_done;
        logic        chk_hold;
        logic [2:0]  exp_row;
        logic [2:0]  exp_col;
        logic [71:0] exp_win;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    conv33_window_if #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) bus ();

    conv33_window #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    vec_t        vecs[$];
    logic        hold_ok;
    logic [71:0] hold_win;
    logic [2:0]  hold_row, hold_col;
    int          strobes;
    logic [71:0] first_win, last_win;
    logic [5:0]  first_idx, last_idx;
    logic        last_done;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] dut_win();
        return {bus.data_0_0, bus.data_0_1, bus.data_0_2,
                bus.data_1_0, bus.data_1_1, bus.data_1_2,
                bus.data_2_0, bus.data_2_1, bus.data_2_2};
    endfunction

    function automatic logic [7:0] pix(input int base, input int r, input int c);
        return 8'(base + r * int'(W) + c);
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " en"}, 72'(bus.conv33_en), 72'(0));
        check({tag, " done"}, 72'(bus.frame_done), 72'(0));
        check({tag, " row"}, 72'(bus.out_row), 72'(0));
        check({tag, " col"}, 72'(bus.out_col), 72'(0));
        check({tag, " win"}, dut_win(), 72'(0));
    endtask

    task automatic add_idle(input int n);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v          = '0;
            v.chk_hold = hold_ok;
            v.exp_win  = hold_win;
            v.exp_row  = hold_row;
            v.exp_col  = hold_col;
            vecs.push_back(v);
        end
    endtask

    task automatic add_frame(input int base, input bit gap, input bit with_start, input int n_pix);
        vec_t v;
        int   r, c;
        for (int k = 0; k < n_pix; k++) begin
            r = k / int'(W);
            c = k % int'(W);
            if (gap) add_idle(int'($urandom_range(0, 2)));
            v       = '0;
            v.valid = 1'b1;
            v.start = with_start && (k == 0);
            v.data  = pix(base, r, c);
            if (r >= 2 && c >= 2) begin
                v.exp_en   = 1'b1;
                v.exp_row  = 3'(r - 2);
                v.exp_col  = 3'(c - 2);
                v.exp_done = (r == int'(H) - 1) && (c == int'(W) - 1);
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        v.exp_win[71 - 8 * (3 * i + j) -: 8] = pix(base, r - 2 + i, c - 2 + j);
                    end
                end
                hold_ok  = 1'b1;
                hold_win = v.exp_win;
                hold_row = v.exp_row;
                hold_col = v.exp_col;
            end else begin
                hold_ok = 1'b0;
            end
            vecs.push_back(v);
        end
    endtask

    task automatic apply_vecs();
        strobes = 0;
        foreach (vecs[k]) begin
            bus.start    = vecs[k].start;
            bus.in_valid = vecs[k].valid;
            bus.in_data  = vecs[k].data;
            @(posedge clk);
            #1;
            check($sformatf("en[%0d]", k), 72'(bus.conv33_en), 72'(vecs[k].exp_en));
            check($sformatf("done[%0d]", k), 72'(bus.frame_done), 72'(vecs[k].exp_done));
            if (vecs[k].exp_en || vecs[k].chk_hold) begin
                check($sformatf("win[%0d]", k), dut_win(), vecs[k].exp_win);
                check($sformatf("row[%0d]", k), 72'(bus.out_row), 72'(vecs[k].exp_row));
                check($sformatf("col[%0d]", k), 72'(bus.out_col), 72'(vecs[k].exp_col));
            end
            if (bus.conv33_en) begin
                strobes++;
                if (strobes == 1) begin
                    first_win = dut_win();
                    first_idx = {bus.out_row, bus.out_col};
                end
                last_win  = dut_win();
                last_idx  = {bus.out_row, bus.out_col};
                last_done = bus.frame_done;
            end
        end
        bus.start = 1'b0;
        vecs.delete();
    endtask

    localparam logic [71:0] WinA0 = 72'h01_02_03_06_07_08_0b_0c_0d;
    localparam logic [71:0] WinA8 = 72'h0d_0e_0f_12_13_14_17_18_19;
    localparam logic [71:0] WinB0 = 72'h65_66_67_6a_6b_6c_6f_70_71;
    localparam logic [71:0] WinB8 = 72'h71_72_73_76_77_78_7b_7c_7d;

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        hold_ok      = 1'b0;
        hold_win     = '0;
        hold_row     = '0;
        hold_col     = '0;

        #2 rst = 1'b0;
        #1 check_zero("por");
        #19 rst = 1'b1;
        @(posedge clk);
        #1 check_zero("idle after reset");

        // Basic frame 1..25, then frame 101..125 back-to-back with no idle cycle.
        add_frame(1, 1'b0, 1'b0, 25);
        apply_vecs();
        check("basic strobes", 72'(strobes), 72'(9));
        check("basic first win", first_win, WinA0);
        check("basic first idx", 72'(first_idx), 72'(0));
        check("basic last win", last_win, WinA8);
        check("basic last idx", 72'(last_idx), 72'({3'd2, 3'd2}));
        check("basic last done", 72'(last_done), 72'(1));

        add_frame(101, 1'b0, 1'b0, 25);
        apply_vecs();
        check("b2b strobes", 72'(strobes), 72'(9));
        check("b2b first win", first_win, WinB0);
        check("b2b last win", last_win, WinB8);
        check("b2b last done", 72'(last_done), 72'(1));

        // Gapped frame: outputs must hold across idle cycles.
        add_idle(2);
        add_frame(1, 1'b1, 1'b0, 25);
        add_idle(2);
        apply_vecs();
        check("gap strobes", 72'(strobes), 72'(9));
        check("gap first win", first_win, WinA0);
        check("gap last win", last_win, WinA8);

        // Start mid-frame at pixel 8: the restart pixel is (0,0) of a fresh frame.
        add_frame(101, 1'b0, 1'b0, 7);
        add_frame(1, 1'b0, 1'b1, 25);
        apply_vecs();
        check("start strobes", 72'(strobes), 72'(9));
        check("start first win", first_win, WinA0);
        check("start last win", last_win, WinA8);

        // Async reset between edges after pixel 17.
        add_frame(101, 1'b0, 1'b0, 17);
        apply_vecs();
        #2 rst = 1'b0;
        #1 check_zero("mid reset");
        bus.in_valid = 1'b0;
        hold_ok      = 1'b0;
        #1 rst = 1'b1;
        add_frame(1, 1'b0, 1'b0, 25);
        add_idle(3);
        apply_vecs();
        check("reset strobes", 72'(strobes), 72'(9));
        check("reset first win", first_win, WinA0);
        check("reset last win", last_win, WinA8);
        check("reset last idx", 72'(last_idx), 72'({3'd2, 3'd2}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
